// File: rtl/mul_shift_add_32bit.sv
// rtl/mul_shift_add_32bit.sv - sequential shift-add signed/unsigned multiplier, 64-bit product
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

module msa_cla_adder #(
    parameter int W = `WORD_LENGTH
) (
    input  logic [0:W-1] i_a,
    input  logic [0:W-1] i_b,
    input  logic         i_c,
    output logic [0:W-1] o_sum,
    output logic         o_c
);
    localparam int NG = W / 4;

    // Little-endian view of the MSB-first operands keeps the carry chain readable.
    logic [W-1:0]  w_x;
    logic [W-1:0]  w_y;
    logic [W-1:0]  w_g;
    logic [W-1:0]  w_p;
    logic [W-1:0]  w_c;
    logic [NG-1:0] w_gg;
    logic [NG-1:0] w_gp;
    logic [NG:0]   w_cg;

    assign w_x = i_a;
    assign w_y = i_b;
    assign w_g = w_x & w_y;
    assign w_p = w_x ^ w_y;

    always_comb begin
        w_gg = '0;
        w_gp = '0;
        w_c  = '0;
        w_cg = '0;
        w_cg[0] = i_c;
        for (int k = 0; k < NG; k++) begin
            w_gg[k] = w_g[4*k+3]
                    | (w_p[4*k+3] & w_g[4*k+2])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
            w_gp[k] = w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_p[4*k];
            w_c[4*k]   = w_cg[k];
            w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_cg[k]);
            w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+1] & w_p[4*k] & w_cg[k]);
            w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_cg[k]);
            w_cg[k+1] = w_gg[k] | (w_gp[k] & w_cg[k]);
        end
    end

    assign o_sum = w_p ^ w_c;
    assign o_c   = w_cg[NG];
endmodule

module mul_shift_add_32bit #(
    parameter int WORD_LENGTH = `WORD_LENGTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   signedOp,
    input  logic [0:WORD_LENGTH-1] a,
    input  logic [0:WORD_LENGTH-1] b,
    output logic                   busy,
    output logic                   done,
    output logic [0:WORD_LENGTH-1] resHi,
    output logic [0:WORD_LENGTH-1] resLo,
    output logic                   ovl
);
    localparam int CW = $clog2(WORD_LENGTH);
    localparam logic [CW-1:0] LAST = CW'(WORD_LENGTH - 1);
    localparam logic [0:WORD_LENGTH-1] ONE = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [CW-1:0]          r_cnt;
    logic [0:WORD_LENGTH-1] r_mcand;
    logic [0:WORD_LENGTH-1] r_mpl;
    logic [0:WORD_LENGTH-1] r_acc;
    logic                   r_neg;
    logic                   r_signed;
    logic                   r_done;
    logic [0:WORD_LENGTH-1] r_res_hi;
    logic [0:WORD_LENGTH-1] r_res_lo;
    logic                   r_ovl;

    logic [0:WORD_LENGTH-1] w_mag_a;
    logic [0:WORD_LENGTH-1] w_mag_b;
    logic [0:WORD_LENGTH-1] w_addend;
    logic [0:WORD_LENGTH-1] w_sum;
    logic                   w_cout;
    logic [0:WORD_LENGTH-1] w_neg_lo;
    logic                   w_neg_lo_c;
    logic [0:WORD_LENGTH-1] w_neg_hi;
    logic                   w_neg_hi_unused_c;
    logic [0:WORD_LENGTH-1] w_prod_hi;
    logic [0:WORD_LENGTH-1] w_prod_lo;
    logic                   w_ovl;

    // 0x80000000 negates to itself, which is exactly its unsigned magnitude.
    assign w_mag_a  = (signedOp && a[0]) ? (~a + ONE) : a;
    assign w_mag_b  = (signedOp && b[0]) ? (~b + ONE) : b;
    assign w_addend = r_mpl[WORD_LENGTH-1] ? r_mcand : '0;

    msa_cla_adder #(.W(WORD_LENGTH)) u_step_add (
        .i_a   (r_acc),
        .i_b   (w_addend),
        .i_c   (1'b0),
        .o_sum (w_sum),
        .o_c   (w_cout)
    );

    // Two's complement of {acc, mpl}: +1 enters the low half, its carry feeds the high half.
    msa_cla_adder #(.W(WORD_LENGTH)) u_neg_lo (
        .i_a   (~r_mpl),
        .i_b   ('0),
        .i_c   (1'b1),
        .o_sum (w_neg_lo),
        .o_c   (w_neg_lo_c)
    );

    msa_cla_adder #(.W(WORD_LENGTH)) u_neg_hi (
        .i_a   (~r_acc),
        .i_b   ('0),
        .i_c   (w_neg_lo_c),
        .o_sum (w_neg_hi),
        .o_c   (w_neg_hi_unused_c)
    );

    assign w_prod_hi = r_neg ? w_neg_hi : r_acc;
    assign w_prod_lo = r_neg ? w_neg_lo : r_mpl;
    assign w_ovl     = r_signed ? (w_prod_hi != {WORD_LENGTH{w_prod_lo[0]}})
                                : (w_prod_hi != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (r_cnt == LAST) w_next = FIN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mpl    <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_signed <= 1'b0;
            r_done   <= 1'b0;
            r_res_hi <= '0;
            r_res_lo <= '0;
            r_ovl    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mcand  <= w_mag_a;
                        r_mpl    <= w_mag_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_neg    <= signedOp & (a[0] ^ b[0]);
                        r_signed <= signedOp;
                    end
                end
                RUN: begin
                    // The adder carry is consumed by the shift, so it never needs its own flop.
                    r_acc <= {w_cout, w_sum[0:WORD_LENGTH-2]};
                    r_mpl <= {w_sum[WORD_LENGTH-1], r_mpl[0:WORD_LENGTH-2]};
                    r_cnt <= r_cnt + CW'(1);
                end
                FIN: begin
                    r_res_hi <= w_prod_hi;
                    r_res_lo <= w_prod_lo;
                    r_ovl    <= w_ovl;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (r_state != IDLE);
    assign done  = r_done;
    assign resHi = r_res_hi;
    assign resLo = r_res_lo;
    assign ovl   = r_ovl;
endmodule

// File: tb/tb_mul_shift_add_32bit.sv
// tb/tb_mul_shift_add_32bit.sv - self-checking bench for mul_shift_add_32bit
module tb_mul_shift_add_32bit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signedOp;
    logic [0:31] a_in;
    logic [0:31] b_in;
    logic        busy;
    logic        done;
    logic [0:31] res_hi;
    logic [0:31] res_lo;
    logic        ovl;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        bit          ovl;
    } vec_t;

    vec_t        vecs[11];
    logic [31:0] corner[5];

    always #5 clk = ~clk;

    mul_shift_add_32bit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .signedOp (signedOp),
        .a        (a_in),
        .b        (b_in),
        .busy     (busy),
        .done     (done),
        .resHi    (res_hi),
        .resLo    (res_lo),
        .ovl      (ovl)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // Product from plain integer arithmetic; overflow from the representable range.
    function automatic logic [64:0] model(input bit sgn, input logic [31:0] x, input logic [31:0] y);
        longint      sp;
        logic [63:0] up;
        bit          ov;
        if (sgn) begin
            sp = longint'($signed(x)) * longint'($signed(y));
            ov = (sp > 64'sh7FFFFFFF) || (sp < -64'sh80000000);
            up = 64'(sp);
        end else begin
            up = {32'd0, x} * {32'd0, y};
            ov = (up > 64'hFFFFFFFF);
        end
        return {ov, up};
    endfunction

    task automatic issue(input bit sgn, input logic [31:0] x, input logic [31:0] y);
        start    = 1'b1;
        signedOp = sgn;
        a_in     = x;
        b_in     = y;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        signedOp = ~sgn;
        a_in     = $urandom;
        b_in     = $urandom;
    endtask

    task automatic wait_done(input int from, input bit chk_hold, input logic [31:0] hold_lo,
                             output int lat);
        lat = -1;
        for (int k = from + 1; k <= from + 60; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k + 1;
                break;
            end
            if (chk_hold) check("hold_resLo", 64'(res_lo), 64'(hold_lo));
        end
    endtask

    task automatic do_op(input string nm, input bit sgn, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el, input bit eo);
        int lat;
        issue(sgn, x, y);
        check({nm, "_busy_run"}, 64'(busy), 64'(1));
        wait_done(0, 1'b0, 32'd0, lat);
        check({nm, "_latency"}, 64'(lat), 64'(34));
        check({nm, "_busy_done"}, 64'(busy), 64'(0));
        check({nm, "_resHi"}, 64'(res_hi), 64'(eh));
        check({nm, "_resLo"}, 64'(res_lo), 64'(el));
        check({nm, "_ovl"}, 64'(ovl), 64'(eo));
        @(negedge clk);
        check({nm, "_done_pulse"}, 64'(done), 64'(0));
    endtask

    initial begin
        int          lat;
        int          pulses;
        bit          sgn;
        logic [31:0] x;
        logic [31:0] y;
        logic [64:0] m;

        vecs[0]  = '{1'b0, 32'd10,         32'd5,          32'h00000000, 32'h00000032, 1'b0};
        vecs[1]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 32'h00000001, 1'b1};
        vecs[2]  = '{1'b1, 32'hFFFFFFFD,   32'd7,          32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[3]  = '{1'b1, 32'h80000000,   32'h80000000,   32'h40000000, 32'h00000000, 1'b1};
        vecs[4]  = '{1'b0, 32'd0,          32'h12345678,   32'h00000000, 32'h00000000, 1'b0};
        vecs[5]  = '{1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000, 32'h00000001, 1'b0};
        vecs[6]  = '{1'b1, 32'hFFFFFFFF,   32'h80000000,   32'h00000000, 32'h80000000, 1'b1};
        vecs[7]  = '{1'b0, 32'h00010000,   32'h00010000,   32'h00000001, 32'h00000000, 1'b1};
        vecs[8]  = '{1'b1, 32'h7FFFFFFF,   32'h7FFFFFFF,   32'h3FFFFFFF, 32'h00000001, 1'b1};
        vecs[9]  = '{1'b1, 32'h80000000,   32'd1,          32'hFFFFFFFF, 32'h80000000, 1'b0};
        vecs[10] = '{1'b0, 32'h80000000,   32'd2,          32'h00000001, 32'h00000000, 1'b1};
        corner   = '{32'h0, 32'h1, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF};

        rst      = 1'b0;
        start    = 1'b0;
        signedOp = 1'b0;
        a_in     = '0;
        b_in     = '0;
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_resHi", 64'(res_hi), 64'(0));
        check("rst_resLo", 64'(res_lo), 64'(0));
        check("rst_ovl", 64'(ovl), 64'(0));
        start = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_held_busy", 64'(busy), 64'(0));
        start = 1'b0;
        rst   = 1'b1;

        for (int i = 0; i < 11; i++) begin
            do_op("vec", vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].ovl);
        end

        for (int i = 0; i < 40; i++) begin
            sgn = 1'($urandom_range(0, 1));
            x   = $urandom;
            y   = $urandom;
            if ($urandom_range(0, 3) == 0) x = corner[$urandom_range(0, 4)];
            if ($urandom_range(0, 3) == 0) y = corner[$urandom_range(0, 4)];
            m = model(sgn, x, y);
            do_op("rand", sgn, x, y, m[63:32], m[31:0], m[64]);
        end

        issue(1'b0, 32'd6, 32'd7);
        repeat (5) @(negedge clk);
        start    = 1'b1;
        signedOp = 1'b0;
        a_in     = 32'd2;
        b_in     = 32'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done(6, 1'b0, 32'd0, lat);
        check("ignore_latency", 64'(lat), 64'(34));
        check("ignore_resLo", 64'(res_lo), 64'h2A);
        check("ignore_resHi", 64'(res_hi), 64'(0));
        pulses = 0;
        repeat (45) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("ignore_extra_done", 64'(pulses), 64'(0));
        check("ignore_busy_after", 64'(busy), 64'(0));

        issue(1'b0, 32'd6, 32'd7);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_resHi", 64'(res_hi), 64'(0));
        check("abort_resLo", 64'(res_lo), 64'(0));
        check("abort_ovl", 64'(ovl), 64'(0));
        @(negedge clk);
        rst    = 1'b1;
        pulses = 0;
        repeat (45) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("abort_no_done", 64'(pulses), 64'(0));
        check("abort_resLo_kept", 64'(res_lo), 64'(0));
        do_op("after_abort", 1'b0, 32'd3, 32'd4, 32'd0, 32'h0000000C, 1'b0);

        issue(1'b0, 32'd10, 32'd5);
        wait_done(0, 1'b0, 32'd0, lat);
        check("b2b_first_latency", 64'(lat), 64'(34));
        check("b2b_first_resLo", 64'(res_lo), 64'h32);
        issue(1'b0, 32'd2, 32'd3);
        check("b2b_done_single", 64'(done), 64'(0));
        check("b2b_busy", 64'(busy), 64'(1));
        check("b2b_resLo_kept", 64'(res_lo), 64'h32);
        wait_done(0, 1'b1, 32'h32, lat);
        check("b2b_second_latency", 64'(lat), 64'(34));
        check("b2b_second_resLo", 64'(res_lo), 64'h6);
        check("b2b_second_resHi", 64'(res_hi), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
